// File: rtl/ex_muldiv.sv
// Iterative 32x32 multiply/divide unit for EX; HI/LO update on the falling edge.
// Define MULDIV_DIV_EN to include DIV/DIVU; without it only MULT/MULTU are accepted.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic        neg_p;
  logic        sa, sb, accept;
  logic [31:0] abs_a, abs_b;
  logic [32:0] sum;
  logic [63:0] acc_step, res;
`ifdef MULDIV_DIV_EN
  logic        div_r, dz, neg_r, ge;
  logic [32:0] shifted;
`endif

  always_comb begin
    sa     = ~op[0] & a[31];
    sb     = ~op[0] & b[31];
    abs_a  = sa ? -a : a;
    abs_b  = sb ? -b : b;
`ifdef MULDIV_DIV_EN
    accept = start & ~flush;
`else
    accept = start & ~flush & ~op[1];
`endif
    // Multiply: acc holds {partial product, remaining multiplier bits}
    sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    acc_step = {sum, acc[31:1]};
    res      = neg_p ? -acc : acc;
`ifdef MULDIV_DIV_EN
    // Divide reuses acc as {remainder, dividend/quotient}
    shifted = {acc[63:32], acc[31]};
    ge      = shifted >= {1'b0, opnd};
    if (div_r) begin
      acc_step = ge ? {shifted[31:0] - opnd, acc[30:0], 1'b1}
                    : {shifted[31:0], acc[30:0], 1'b0};
      res      = {neg_r ? -acc[63:32] : acc[63:32],
                  neg_p ? -acc[31:0]  : acc[31:0]};
    end
`endif
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 6'd31;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      acc   <= '0;
      opnd  <= '0;
      neg_p <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_r       <= 1'b0;
      dz          <= 1'b0;
      neg_r       <= 1'b0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            cnt   <= 6'd31;
            state <= CALC;
            neg_p <= sa ^ sb;
            opnd  <= abs_a;
            acc   <= {32'd0, abs_b};
`ifdef MULDIV_DIV_EN
            div_r <= op[1];
            dz    <= op[1] && (b == '0);
            neg_r <= sa;
            if (op[1]) begin
              opnd <= abs_b;
              acc  <= {32'd0, abs_a};
              if (b == '0) begin
                // Divide by zero skips the iterations; acc carries the final HI/LO
                acc   <= {a, 32'hFFFF_FFFF};
                neg_p <= 1'b0;
                neg_r <= 1'b0;
                state <= FIXUP;
              end
            end
`endif
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 6'd31;
          end else begin
            acc <= acc_step;
            if (cnt == 6'd0) begin
              cnt   <= 6'd31;
              state <= FIXUP;
            end else begin
              cnt <= cnt - 6'd1;
            end
          end
        end
        FIXUP: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi   <= res[63:32];
            lo   <= res[31:0];
            done <= 1'b1;
`ifdef MULDIV_DIV_EN
            if (div_r) div_by_zero <= dz;
`endif
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef MULDIV_DIV_EN
  assign div_by_zero = 1'b0;
`endif

endmodule
